uart_tx_arbiter: RTL



---
 rtl/uart_tx_arbiter.sv | 103 ++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, frame-locking sequencer sharing one UART TX core among NUM_REQ byte streams.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int LOCK_TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  output logic                 lock_drop
);
  localparam int PW = $clog2(NUM_REQ);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, HOLD} state_t;
  state_t state, state_nx;
  logic [PW-1:0] ptr, ptr_nx, pick, idx, sel;
  logic found, last_flag, last_nx, drop_nx, timeout;
  logic [NUM_REQ-1:0] grant_nx, ready_nx;
  logic [7:0] data_nx, data_sel;
  logic [15:0] cnt, cnt_nx;
  assign timeout  = (LOCK_TIMEOUT != 0) && (cnt == 16'(LOCK_TIMEOUT - 1));
  assign sel      = (state == IDLE) ? pick : ptr;
  assign data_sel = req_data[{sel, 3'b000} +: 8];
  // descending scan so the nearest valid index after ptr is the final assignment
  always_comb begin
    pick = ptr;
    found = 1'b0;
    idx = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = PW'((int'(ptr) + i) % NUM_REQ);
      if (req_valid[idx]) begin
        pick = idx;
        found = 1'b1;
      end
    end
  end
  always_comb begin
    state_nx = state;
    grant_nx = grant;
    ptr_nx = ptr;
    data_nx = tx_data;
    last_nx = last_flag;
    cnt_nx = cnt;
    drop_nx = 1'b0;
    ready_nx = (state == ISSUE) ? grant : '0;
    case (state)
      IDLE: if (found && !tx_busy) begin
        state_nx = ISSUE;
        grant_nx = NUM_REQ'(1) << pick;
        ptr_nx = pick;
        data_nx = data_sel;
        last_nx = req_last[sel];
      end
      ISSUE: state_nx = WAIT_BUSY;
      WAIT_BUSY: state_nx = tx_busy ? WAIT_DONE : WAIT_BUSY;
      WAIT_DONE: if (!tx_busy) begin
        state_nx = last_flag ? IDLE : HOLD;
        grant_nx = last_flag ? '0 : grant;
        cnt_nx = '0;
      end
      HOLD: if (req_valid[ptr]) begin
        state_nx = ISSUE;
        data_nx = data_sel;
        last_nx = req_last[sel];
      end else if (timeout) begin
        state_nx = IDLE;
        grant_nx = '0;
        drop_nx = 1'b1;
      end else begin
        cnt_nx = cnt + 16'd1;
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      grant <= '0;
      ptr <= PW'(NUM_REQ - 1);
      tx_data <= 8'h00;
      last_flag <= 1'b0;
      cnt <= '0;
      tx_start <= 1'b0;
      req_ready <= '0;
      lock_drop <= 1'b0;
    end else begin
      state <= state_nx;
      grant <= grant_nx;
      ptr <= ptr_nx;
      tx_data <= data_nx;
      last_flag <= last_nx;
      cnt <= cnt_nx;
      tx_start <= (state == ISSUE);
      req_ready <= ready_nx;
      lock_drop <= drop_nx;
    end
  end
endmodule
